rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Eight-requester round-robin arbiter that shares one downstream resource, such as an 8:3 encoded result bus or a shared datapath port. It registers a one-hot grant together with its 3-bit encoded index and holds the grant until the owner drops its request. After each release it rotates priority so that no requester starves. It sits between the eight requesting clients and the shared resource's select input.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum grant hold in cycles when another request is pending (used only with `ARB_TIMEOUT_EN`); legal range 2–255.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset is asynchronous and active-low.
- `req` input, 8 bits: level requests; `req[i]` is held high for as long as client i wants or uses the resource.
- `gnt` output, 8 bits: registered grant, one-hot or zero.
- `gnt_id` output, 3 bits: binary index of the granted client; valid only while `gnt_valid` is high.
- `gnt_valid` output, 1 bit: high exactly when `gnt` is nonzero.
- `timeout` output, 1 bit: one-cycle pulse when a grant is revoked by timeout.

## Operation
- **States.**
  - IDLE: no grant.
  - GRANT: exactly one grant is held.
- **Winner selection (combinational).** Search `req` starting at index `ptr` and moving upward modulo 8. The first set bit wins. `ptr` is a 3-bit register.
- **IDLE.**
  - If `req` is nonzero, go to GRANT at the next edge: `gnt` becomes one-hot for the winner, `gnt_id` becomes its index, and `gnt_valid` becomes 1.
  - If `req` is zero, stay in IDLE.
- **GRANT, owner still requesting.** While `req[gnt_id]` is 1, hold the grant unchanged. Changes on other `req` bits are ignored.
- **GRANT, owner releases.** On an edge where `req[gnt_id]` is 0:
  - `ptr` becomes `gnt_id+1` modulo 8.
  - The winner is computed from that new pointer, with the releasing bit masked.
  - If a winner exists, grant it at this same edge and stay in GRANT (zero-bubble handover).
  - Otherwise clear `gnt`, `gnt_valid` and `gnt_id`, and go to IDLE.
- **Grant integrity.** `gnt` never has more than one bit set. The granted client may change only on a release or a timeout edge.
- **Reset.**
  - Reset values: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, `ptr`=0, state IDLE, hold counter 0.
  - Reset asserted mid-grant clears all of these immediately, without waiting for a clock edge.
  - After `rst_n` rises, the first arbitration uses `ptr`=0.

## Timing
- **Request to grant from IDLE.** `req` sampled at edge N produces `gnt` high after edge N, a latency of 1 cycle.
- **Release.** `req[gnt_id]` sampled low at edge N:
  - The old grant drops after edge N.
  - The new grant, if any, rises after the same edge N.
  - The old owner therefore sees `gnt` high for exactly one cycle after lowering `req`.
- **Combinational paths.** There is no combinational path from `req` to any output.
- **Simultaneous events.**
  - Release coinciding with a new request from the same client: the request is ignored because its bit is masked. The client re-enters rotation only when `ptr` next reaches it.
  - Release while all other requests are 0: go to IDLE.

## Configuration
- **`ARB_TIMEOUT_EN` defined:**
  - An 8-bit hold counter resets to 0 on every new grant and increments each cycle in GRANT.
  - Revocation condition: the counter equals `TIMEOUT_CYCLES-1` AND at least one other `req` bit is set.
  - On revocation the grant is revoked exactly as if released: `ptr` becomes `gnt_id+1`, the next winner is granted, and `timeout` pulses high for one cycle.
  - If no other request is pending, the counter saturates and the grant is held.
- **`ARB_TIMEOUT_EN` not defined:**
  - No counter is built and `timeout` is tied to 0.
  - A grant is held indefinitely while its owner keeps `req` high.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-grant, with no clock edge during reset -> `gnt`=0x00, `gnt_valid`=0 and `gnt_id`=0 immediately. After release with `req`=0x01, `gnt`=0x01 one cycle later.
- **Single requester.** Step `req` through 0x01 to 0x80, one client at a time, each dropped before the next -> `gnt` equals `req` one cycle later and `gnt_id` runs 0 to 7. Each `req` drop returns the arbiter to IDLE (`gnt`=0).
- **Rotation.** From reset with `req`=0xFF held, and each owner dropping its bit for one cycle after 2 cycles of grant -> the grant sequence is 0,1,2,…,7,0. No client is granted twice before every pending client has been granted once.
- **Zero-bubble handover.** Client 2 owns the grant and `req`=0x24 -> drop bit 2 so `req`=0x20 -> on the next edge `gnt` goes directly 0x04 to 0x20 and `gnt_valid` stays 1.
- **Timeout.** With `ARB_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=4, client 0 holds `req` high with `req`=0x11 -> `gnt`=0x01 for 4 cycles, then `gnt`=0x10 with a 1-cycle `timeout` pulse. With `req`=0x01 only, `gnt`=0x01 persists beyond 20 cycles. Without the macro, `gnt`=0x01 persists beyond 20 cycles and `timeout` stays 0.
- **Pattern sweep.** Apply `req` values 0xAA, 0x55, 0x33 and 0xCC, with every owner releasing after 1 cycle -> the grants match a round-robin reference model every cycle. Assert one-hot `gnt` and consistency between `gnt_id` and `gnt` every cycle.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 - eight-requester round-robin arbiter with registered grant.
//
// Purpose:
//   Shares one downstream resource among eight level-requesting clients. A
//   grant is held until its owner drops the request; priority then rotates to
//   the index just above the releasing owner, so no requester starves. When
//   the owner releases and another client is waiting, the new grant is issued
//   on the same edge (zero-bubble handover).
//
// Build option:
//   ARB_TIMEOUT_EN - when defined, an 8-bit hold counter revokes a grant that
//                    has been held for TIMEOUT_CYCLES cycles while at least one
//                    other client is requesting. When undefined, no counter is
//                    built and `timeout` is constant 0.
//
// Parameters:
//   TIMEOUT_CYCLES - maximum grant hold in cycles under contention (2..255);
//                    only meaningful with ARB_TIMEOUT_EN.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   req       in   8  level requests, one bit per client
//   gnt       out  8  registered one-hot (or zero) grant
//   gnt_id    out  3  binary index of the granted client (0 when idle)
//   gnt_valid out  1  high exactly when gnt is nonzero
//   timeout   out  1  one-cycle pulse on a timeout revocation

module rr_arbiter_8 #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Reject out-of-range hold limits at elaboration time.
    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("rr_arbiter_8: TIMEOUT_CYCLES must lie in 2..255");
    end

    // Round-robin search: first set bit of reqv at or above start, modulo 8.
    // Result is {found, index}. Walking the offsets from high to low lets the
    // lowest offset win without an early exit.
    function automatic logic [3:0] rr_pick(input logic [7:0] reqv,
                                           input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (reqv[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Binary index to one-hot grant vector.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    state_t     state_r;
    logic [2:0] ptr_r;
    logic [7:0] gnt_r;
    logic [2:0] gnt_id_r;
    logic       gnt_valid_r;
    logic       timeout_r;

    logic       owner_req_s;
    logic       others_s;
    logic       release_s;
    logic       revoke_s;
    logic       handover_s;
    logic [2:0] next_ptr_s;
    logic [7:0] search_vec_s;
    logic [2:0] search_base_s;
    logic [3:0] pick_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST_C = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] hold_cnt_r;

    // Revoke the grant when the hold limit is reached under contention.
    always_comb begin
        revoke_s = 1'b0;
        if ((state_r == ST_GRANT) && owner_req_s &&
            (hold_cnt_r == HOLD_LAST_C) && others_s) begin
            revoke_s = 1'b1;
        end else begin
            revoke_s = 1'b0;
        end
    end

    // Hold counter: cleared on each new grant, counts grant cycles, and
    // saturates at the limit so a late-arriving request revokes promptly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else if (state_r != ST_GRANT) begin
            hold_cnt_r <= 8'd0;
        end else if (handover_s) begin
            hold_cnt_r <= 8'd0;
        end else if (hold_cnt_r != HOLD_LAST_C) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end
`else
    // Without the timeout option a grant is never revoked.
    always_comb begin
        revoke_s = 1'b0;
    end
`endif

    // Release/handover detection and winner search. In GRANT the search starts
    // just above the current owner with the owner's bit masked, so a client
    // that drops and re-raises its request on the release edge is skipped.
    always_comb begin
        owner_req_s   = req[gnt_id_r];
        others_s      = |(req & ~gnt_r);
        next_ptr_s    = gnt_id_r + 3'd1;
        release_s     = 1'b0;
        search_vec_s  = req;
        search_base_s = ptr_r;
        if (state_r == ST_GRANT) begin
            release_s     = !owner_req_s;
            search_vec_s  = req & ~gnt_r;
            search_base_s = next_ptr_s;
        end else begin
            release_s     = 1'b0;
            search_vec_s  = req;
            search_base_s = ptr_r;
        end
        handover_s = release_s || revoke_s;
        pick_s     = rr_pick(search_vec_s, search_base_s);
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'd0;
            gnt_r       <= 8'd0;
            gnt_id_r    <= 3'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timeout_r <= 1'b0;
                    if (pick_s[3]) begin
                        state_r     <= ST_GRANT;
                        gnt_r       <= onehot8(pick_s[2:0]);
                        gnt_id_r    <= pick_s[2:0];
                        gnt_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        gnt_r       <= 8'd0;
                        gnt_id_r    <= 3'd0;
                        gnt_valid_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    timeout_r <= revoke_s;
                    if (handover_s) begin
                        ptr_r <= next_ptr_s;
                        if (pick_s[3]) begin
                            state_r     <= ST_GRANT;
                            gnt_r       <= onehot8(pick_s[2:0]);
                            gnt_id_r    <= pick_s[2:0];
                            gnt_valid_r <= 1'b1;
                        end else begin
                            state_r     <= ST_IDLE;
                            gnt_r       <= 8'd0;
                            gnt_id_r    <= 3'd0;
                            gnt_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r     <= ST_GRANT;
                        gnt_r       <= gnt_r;
                        gnt_id_r    <= gnt_id_r;
                        gnt_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ptr_r       <= 3'd0;
                    gnt_r       <= 8'd0;
                    gnt_id_r    <= 3'd0;
                    gnt_valid_r <= 1'b0;
                    timeout_r   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios followed by a
// pattern sweep and randomized requests, all compared every cycle against a
// behavioural round-robin model.

module tb_rr_arbiter_8;

    localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: current owner (-1 = none), rotation start,
    // cycles held, and expected timeout pulse.
    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_tmo = 1'b0;

    rr_arbiter_8 #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic int rr_search(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (start + k) % 8;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        logic [7:0] others;
        bit expire;
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            m_owner = rr_search(r, m_ptr);
            m_cnt   = 0;
        end else begin
            others = r & ~(8'd1 << m_owner);
            expire = TMO_EN && r[m_owner] && (m_cnt == TMO - 1) && (others != 8'd0);
            if (!r[m_owner] || expire) begin
                m_tmo   = expire;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = rr_search(others, m_ptr);
                m_cnt   = 0;
            end else if (m_cnt < TMO - 1) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        logic [2:0] eid;
        logic       ev;
        if (m_owner >= 0) begin
            eg  = 8'd1 << m_owner;
            eid = 3'(m_owner);
            ev  = 1'b1;
        end else begin
            eg  = 8'd0;
            eid = 3'd0;
            ev  = 1'b0;
        end
        check({tag, ".gnt"},     {24'd0, gnt},       {24'd0, eg});
        check({tag, ".gnt_id"},  {29'd0, gnt_id},    {29'd0, eid});
        check({tag, ".valid"},   {31'd0, gnt_valid}, {31'd0, ev});
        check({tag, ".timeout"}, {31'd0, timeout},   {31'd0, m_tmo});
        check({tag, ".onehot"},  {31'd0, $onehot0(gnt)}, 32'd1);
    endtask

    // Apply r, take one rising edge, advance the model, check #1 later.
    task automatic step(input logic [7:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] pats [4];
        pats = '{8'hAA, 8'h55, 8'h33, 8'hCC};

        // Reset state
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst.gnt",     {24'd0, gnt},       32'd0);
        check("rst.gnt_id",  {29'd0, gnt_id},    32'd0);
        check("rst.valid",   {31'd0, gnt_valid}, 32'd0);
        check("rst.timeout", {31'd0, timeout},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Single requester walk: grant follows req, each drop returns to idle
        for (int i = 0; i < 8; i++) begin
            v = 8'd1 << i;
            step(v, "single");
            check("single.gnt_eq_req", {24'd0, gnt}, {24'd0, v});
            check("single.id", {29'd0, gnt_id}, 32'(i));
            step(8'h00, "single.drop");
            check("single.idle", {24'd0, gnt}, 32'd0);
        end

        // Asynchronous reset in the middle of a grant
        step(8'h08, "arst.pre");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.gnt",    {24'd0, gnt},       32'd0);
        check("arst.gnt_id", {29'd0, gnt_id},    32'd0);
        check("arst.valid",  {31'd0, gnt_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h01, "arst.post");
        check("arst.post_gnt", {24'd0, gnt}, 32'h01);
        step(8'h00, "arst.drop");

        // Rotation with all clients requesting
        do_reset();
        step(8'hFF, "rot.first");
        for (int k = 0; k < 9; k++) begin
            check("rot.seq", {29'd0, gnt_id}, 32'(k % 8));
            step(8'hFF, "rot.hold");
            v = 8'hFF & ~(8'd1 << (k % 8));
            step(v, "rot.rel");
        end

        // Zero-bubble handover from client 2 to client 5
        do_reset();
        step(8'h04, "zb.grant");
        check("zb.own2", {24'd0, gnt}, 32'h04);
        step(8'h24, "zb.hold");
        check("zb.hold2", {24'd0, gnt}, 32'h04);
        step(8'h20, "zb.hand");
        check("zb.gnt5",  {24'd0, gnt},       32'h20);
        check("zb.valid", {31'd0, gnt_valid}, 32'd1);

        // Long hold / timeout behaviour
`ifdef ARB_TIMEOUT_EN
        do_reset();
        step(8'h11, "tmo.grant");
        check("tmo.own0", {24'd0, gnt}, 32'h01);
        for (int i = 0; i < 3; i++) begin
            step(8'h11, "tmo.hold");
            check("tmo.held", {24'd0, gnt}, 32'h01);
            check("tmo.quiet", {31'd0, timeout}, 32'd0);
        end
        step(8'h11, "tmo.revoke");
        check("tmo.gnt4",  {24'd0, gnt},     32'h10);
        check("tmo.pulse", {31'd0, timeout}, 32'd1);
        step(8'h11, "tmo.after");
        check("tmo.pulse_end", {31'd0, timeout}, 32'd0);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(8'h01, "tmo.solo");
            check("tmo.solo_gnt", {24'd0, gnt}, 32'h01);
        end
`else
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(8'h11, "hold");
            check("hold.gnt", {24'd0, gnt}, 32'h01);
            check("hold.timeout", {31'd0, timeout}, 32'd0);
        end
`endif

        // Pattern sweep, each owner releasing after one cycle
        do_reset();
        foreach (pats[p]) begin
            step(pats[p], "sweep.req");
            for (int i = 0; i < 10; i++) begin
                v = pats[p];
                if (m_owner >= 0) v[m_owner] = 1'b0;
                step(v, "sweep.rel");
                step(pats[p], "sweep.req");
            end
        end

        // Randomized requests with random releases
        for (int i = 0; i < 300; i++) begin
            v = 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 2) == 0) v[m_owner] = 1'b0;
            if ($urandom_range(0, 9) == 0) v = 8'h00;
            step(v, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
